// File: rtl/pool_pkg.sv
// Shared definitions for the pooling PE: op encoding and sum-overflow detection.
package pool_pkg;

  localparam logic [1:0] POOL_OP_LOAD = 2'd0;
  localparam logic [1:0] POOL_OP_SUM  = 2'd1;
  localparam logic [1:0] POOL_OP_MAX  = 2'd2;
  localparam logic [1:0] POOL_OP_MIN  = 2'd3;

  // Classifies a one-bit-wider sum by its top two bits; returns {clip, clip_to_min}.
  function automatic logic [1:0] pool_sat_chk(input logic is_signed, input logic sum_top,
                                               input logic sum_msb);
    logic [1:0] res;
    if (is_signed) begin
      res = {sum_top ^ sum_msb, sum_top};
    end else begin
      res = {sum_top, 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/pool_pe_mslot_if.sv
// Beat and result bundle between the pool controller (master) and one PE lane (slave).
interface pool_pe_mslot_if #(
  parameter int unsigned N_SLOT = 8,
  parameter int unsigned XW     = 8,
  parameter int unsigned ACCW   = 14
);
  localparam int unsigned SW = $clog2(N_SLOT);

  logic            in_vld;
  logic [1:0]      op;
  logic            last;
  logic [SW-1:0]   sel;
  logic [XW-1:0]   x;
  logic [3:0]      shift;
  logic [ACCW-1:0] y;
  logic [SW-1:0]   y_sel;
  logic            y_sat;
  logic            y_vld;

  modport master (
    output in_vld, op, last, sel, x, shift,
    input  y, y_sel, y_sat, y_vld
  );

  modport slave (
    input  in_vld, op, last, sel, x, shift,
    output y, y_sel, y_sat, y_vld
  );

endinterface

// File: rtl/pool_pe_alu.sv
// Combinational next-accumulator, clip flag and result for one beat.
// POOL_PE_AVG_DIV_EN adds a round-half-up right shift on the result of a final SUM.
module pool_pe_alu
  import pool_pkg::*;
#(
  parameter int unsigned XW     = 8,
  parameter int unsigned ACCW   = 14,
  parameter int unsigned SIGNED = 0
) (
  input  logic [1:0]      op_i,
  input  logic            last_i,
  input  logic [3:0]      shift_i,
  input  logic [ACCW-1:0] acc_i,
  input  logic [XW-1:0]   x_i,
  output logic [ACCW-1:0] acc_o,
  output logic            clip_o,
  output logic [ACCW-1:0] y_o
);
  localparam bit Sgn = (SIGNED != 0);

  logic [ACCW-1:0] x_ext;
  logic [ACCW:0]   sum_w;
  logic [1:0]      chk;
  logic [ACCW-1:0] sum_sat;
  logic            x_gt;

  if (ACCW > XW) begin : g_ext
    assign x_ext = {{(ACCW-XW){Sgn & x_i[XW-1]}}, x_i};
  end else begin : g_noext
    assign x_ext = x_i;
  end

  // One extra bit so the sum never wraps before clipping.
  assign sum_w = {Sgn & acc_i[ACCW-1], acc_i} + {Sgn & x_ext[ACCW-1], x_ext};
  assign chk   = pool_sat_chk(Sgn, sum_w[ACCW], sum_w[ACCW-1]);
  assign x_gt  = Sgn ? ($signed(x_ext) > $signed(acc_i)) : (x_ext > acc_i);

  always_comb begin
    sum_sat = sum_w[ACCW-1:0];
    if (chk[1]) begin
      if (!Sgn) begin
        sum_sat = '1;
      end else if (chk[0]) begin
        sum_sat = {1'b1, {(ACCW-1){1'b0}}};
      end else begin
        sum_sat = {1'b0, {(ACCW-1){1'b1}}};
      end
    end
  end

  always_comb begin
    acc_o  = x_ext;
    clip_o = 1'b0;
    unique case (op_i)
      POOL_OP_LOAD: acc_o = x_ext;
      POOL_OP_SUM: begin
        acc_o  = sum_sat;
        clip_o = chk[1];
      end
      POOL_OP_MAX: acc_o = x_gt ? x_ext : acc_i;
      POOL_OP_MIN: acc_o = x_gt ? acc_i : x_ext;
      default: ;
    endcase
  end

`ifdef POOL_PE_AVG_DIV_EN
  localparam int unsigned RW = ACCW + 16;

  logic [RW-1:0] acc_wide;
  logic [RW-1:0] rnd;
  logic [RW-1:0] rnd_sum;

  always_comb begin
    acc_wide = {{16{Sgn & acc_o[ACCW-1]}}, acc_o};
    rnd      = '0;
    if (shift_i != 4'd0) begin
      rnd = RW'(1) << (shift_i - 4'd1);
    end
    rnd_sum = acc_wide + rnd;
    y_o     = acc_o;
    if (op_i == POOL_OP_SUM && last_i) begin
      if (Sgn) begin
        y_o = ACCW'($signed(rnd_sum) >>> shift_i);
      end else begin
        y_o = ACCW'(rnd_sum >> shift_i);
      end
    end
  end
`else
  logic unused_avg;
  assign unused_avg = ^{last_i, shift_i};
  assign y_o        = acc_o;
`endif

endmodule

// File: rtl/pool_pe_mslot.sv
// Multi-slot pooling PE: per-slot accumulators with sticky saturation and a registered result.
// Optional build macro POOL_PE_AVG_DIV_EN enables the averaging shift on final SUM results.
module pool_pe_mslot
  import pool_pkg::*;
#(
  parameter int unsigned N_SLOT = 8,
  parameter int unsigned XW     = 8,
  parameter int unsigned ACCW   = 14,
  parameter int unsigned SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  pool_pe_mslot_if.slave pe_if
);
  localparam int unsigned SW = $clog2(N_SLOT);

  logic [ACCW-1:0]   acc_q [N_SLOT];
  logic [ACCW-1:0]   acc_d [N_SLOT];
  logic [N_SLOT-1:0] sat_q, sat_d;
  logic [ACCW-1:0]   y_q, y_d;
  logic [SW-1:0]     y_sel_q, y_sel_d;
  logic              y_sat_q, y_sat_d;
  logic              y_vld_q, y_vld_d;

  logic [ACCW-1:0]   acc_rd;
  logic [ACCW-1:0]   acc_nxt;
  logic [ACCW-1:0]   y_nxt;
  logic              clip;
  logic              sat_nxt;

  assign acc_rd = acc_q[pe_if.sel];

  pool_pe_alu #(
    .XW    (XW),
    .ACCW  (ACCW),
    .SIGNED(SIGNED)
  ) u_alu (
    .op_i   (pe_if.op),
    .last_i (pe_if.last),
    .shift_i(pe_if.shift),
    .acc_i  (acc_rd),
    .x_i    (pe_if.x),
    .acc_o  (acc_nxt),
    .clip_o (clip),
    .y_o    (y_nxt)
  );

  // clip is only raised by SUM, so MAX/MIN keep the flag as is.
  assign sat_nxt = (pe_if.op == POOL_OP_LOAD) ? 1'b0 : (sat_q[pe_if.sel] | clip);

  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    y_d     = y_q;
    y_sel_d = y_sel_q;
    y_sat_d = y_sat_q;
    y_vld_d = 1'b0;
    if (pe_if.in_vld) begin
      acc_d[pe_if.sel] = acc_nxt;
      sat_d[pe_if.sel] = sat_nxt;
      if (pe_if.last) begin
        y_vld_d = 1'b1;
        y_d     = y_nxt;
        y_sel_d = pe_if.sel;
        y_sat_d = sat_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SLOT); i++) begin
        acc_q[i] <= '0;
      end
      sat_q   <= '0;
      y_q     <= '0;
      y_sel_q <= '0;
      y_sat_q <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      y_q     <= y_d;
      y_sel_q <= y_sel_d;
      y_sat_q <= y_sat_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign pe_if.y     = y_q;
  assign pe_if.y_sel = y_sel_q;
  assign pe_if.y_sat = y_sat_q;
  assign pe_if.y_vld = y_vld_q;

endmodule
